// File: rtl/plic_claim_engine_pkg.sv
// Shared types and constants for the PLIC auto-claim engine.
package plic_claim_engine_pkg;

    localparam logic [31:0] CcAddrDefault = 32'h0020_0004;
    localparam int unsigned HoldoffW      = 4;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_CMPL  = 2'd1,
        ST_CLAIM = 2'd2,
        ST_HOLD  = 2'd3
    } state_e;

    typedef struct packed {
        logic [31:0] addr;
        logic        write;
        logic [31:0] wdata;
        logic [3:0]  wstrb;
        logic        valid;
    } plic_reg_req_t;

    typedef struct packed {
        logic [31:0] rdata;
        logic        error;
        logic        ready;
    } plic_reg_rsp_t;

endpackage

// File: rtl/plic_claim_fifo.sv
// First-word-fall-through FIFO for claimed interrupt IDs; Depth must be a power of two.
module plic_claim_fifo #(
    parameter int unsigned Width = 5,
    parameter int unsigned Depth = 4
) (
    input  logic                     clk_i,
    input  logic                     rst_i,
    input  logic                     push_i,
    input  logic [Width-1:0]         data_i,
    input  logic                     pop_i,
    output logic [Width-1:0]         data_o,
    output logic [$clog2(Depth):0]   level_o,
    output logic                     full_o,
    output logic                     empty_o
);
    localparam int unsigned PtrW = $clog2(Depth);
    localparam int unsigned LvlW = PtrW + 1;

    logic [Width-1:0] mem_q [Depth];
    logic [PtrW-1:0]  wptr_q, wptr_d, rptr_q, rptr_d;
    logic [LvlW-1:0]  level_q, level_d;
    logic             push_ok, pop_ok;

    assign full_o  = level_q == LvlW'(Depth);
    assign empty_o = level_q == '0;
    assign push_ok = push_i && !full_o;
    assign pop_ok  = pop_i && !empty_o;

    // Pointers wrap naturally because Depth is a power of two.
    always_comb begin
        wptr_d  = wptr_q + PtrW'(push_ok);
        rptr_d  = rptr_q + PtrW'(pop_ok);
        level_d = level_q + LvlW'(push_ok) - LvlW'(pop_ok);
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            wptr_q  <= '0;
            rptr_q  <= '0;
            level_q <= '0;
        end else begin
            wptr_q  <= wptr_d;
            rptr_q  <= rptr_d;
            level_q <= level_d;
        end
    end

    always_ff @(posedge clk_i) begin
        if (push_ok) mem_q[wptr_q] <= data_i;
    end

    assign data_o  = mem_q[rptr_q];
    assign level_o = level_q;

endmodule

// File: rtl/plic_claim_engine.sv
// Hardware claim/complete engine for one PLIC target.
// Optional claim counter enabled by defining PLIC_CLAIM_STATS_EN.
module plic_claim_engine
    import plic_claim_engine_pkg::*;
#(
    parameter type         reg_req_t = plic_claim_engine_pkg::plic_reg_req_t,
    parameter type         reg_rsp_t = plic_claim_engine_pkg::plic_reg_rsp_t,
    parameter int unsigned SRCW      = 5,
    parameter int unsigned FifoDepth = 4,
    parameter logic [31:0] CcAddr    = CcAddrDefault,
    parameter int unsigned Holdoff   = 2
) (
    input  logic                        clk_i,
    input  logic                        rst_i,
    input  logic                        irq_i,
    input  logic [SRCW-1:0]             irq_id_i,
    output reg_req_t                    reg_req_o,
    input  reg_rsp_t                    reg_rsp_i,
    output logic                        id_valid_o,
    output logic [SRCW-1:0]             id_o,
    input  logic                        id_ready_i,
    input  logic                        cmpl_valid_i,
    input  logic [SRCW-1:0]             cmpl_id_i,
    output logic                        cmpl_ready_o,
    output logic [$clog2(FifoDepth):0]  level_o,
    output logic                        err_o,
    output logic [31:0]                 claim_cnt_o
);
    state_e              state_q, state_d;
    logic [HoldoffW-1:0] hold_q, hold_d;
    logic [SRCW-1:0]     cmpl_id_q, cmpl_id_d;
    logic                err_q, err_d;
    logic                push, pop, full, empty, rsp_done;
    logic [SRCW-1:0]     claim_id;
    logic                unused_rdata;

    assign claim_id     = reg_rsp_i.rdata[SRCW-1:0];
    assign unused_rdata = ^reg_rsp_i.rdata;
    assign rsp_done     = reg_rsp_i.ready && (state_q == ST_CMPL || state_q == ST_CLAIM);
    // A zero claim result is spurious and an errored one is dropped.
    assign push         = state_q == ST_CLAIM && reg_rsp_i.ready && !reg_rsp_i.error
                          && claim_id != '0;
    assign pop          = id_valid_o && id_ready_i;
    assign cmpl_ready_o = state_q == ST_CMPL && reg_rsp_i.ready;
    assign id_valid_o   = !empty;
    assign err_o        = err_q;

    always_comb begin
        state_d   = state_q;
        hold_d    = hold_q;
        cmpl_id_d = cmpl_id_q;
        err_d     = err_q | (rsp_done && reg_rsp_i.error);
        case (state_q)
            ST_IDLE: begin
                if (cmpl_valid_i) begin
                    state_d   = ST_CMPL;
                    cmpl_id_d = cmpl_id_i;
                end else if (irq_i && irq_id_i != '0 && !full) begin
                    state_d = ST_CLAIM;
                end
            end
            ST_CMPL: if (reg_rsp_i.ready) state_d = ST_IDLE;
            ST_CLAIM: begin
                if (reg_rsp_i.ready) begin
                    if (Holdoff == 0) begin
                        state_d = ST_IDLE;
                    end else begin
                        state_d = ST_HOLD;
                        hold_d  = HoldoffW'(Holdoff);
                    end
                end
            end
            ST_HOLD: begin
                hold_d = hold_q - 1'b1;
                if (hold_q <= HoldoffW'(1)) state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q   <= ST_IDLE;
            hold_q    <= '0;
            cmpl_id_q <= '0;
            err_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            hold_q    <= hold_d;
            cmpl_id_q <= cmpl_id_d;
            err_q     <= err_d;
        end
    end

    // Request fields derive from registered state only, so they stay stable until ready.
    always_comb begin
        reg_req_o = '0;
        if (state_q == ST_CMPL) begin
            reg_req_o.valid            = 1'b1;
            reg_req_o.write            = 1'b1;
            reg_req_o.addr             = CcAddr;
            reg_req_o.wdata[SRCW-1:0]  = cmpl_id_q;
            reg_req_o.wstrb            = '1;
        end else if (state_q == ST_CLAIM) begin
            reg_req_o.valid = 1'b1;
            reg_req_o.addr  = CcAddr;
        end
    end

    plic_claim_fifo #(
        .Width (SRCW),
        .Depth (FifoDepth)
    ) u_fifo (
        .clk_i   (clk_i),
        .rst_i   (rst_i),
        .push_i  (push),
        .data_i  (claim_id),
        .pop_i   (pop),
        .data_o  (id_o),
        .level_o (level_o),
        .full_o  (full),
        .empty_o (empty)
    );

`ifdef PLIC_CLAIM_STATS_EN
    logic [31:0] cnt_q, cnt_d;

    assign cnt_d = (push && cnt_q != '1) ? cnt_q + 32'd1 : cnt_q;

    always_ff @(posedge clk_i) begin
        if (rst_i) cnt_q <= '0;
        else       cnt_q <= cnt_d;
    end

    assign claim_cnt_o = cnt_q;
`else
    assign claim_cnt_o = '0;
`endif

endmodule

// File: tb/tb_plic_claim_engine.sv
// Randomized bench: a PLIC responder plus a queue-based model of the claimed-ID stream.
module tb_plic_claim_engine;
    import plic_claim_engine_pkg::*;

    localparam int          SRCW  = 5;
    localparam int          DEPTH = 4;
    localparam int          HOLD  = 2;
    localparam logic [31:0] CC    = 32'h0020_0004;

    logic            clk_i = 1'b0;
    logic            rst_i;
    logic            irq_i;
    logic [SRCW-1:0] irq_id_i;
    plic_reg_req_t   reg_req_o;
    plic_reg_rsp_t   reg_rsp_i;
    logic            id_valid_o;
    logic [SRCW-1:0] id_o;
    logic            id_ready_i;
    logic            cmpl_valid_i;
    logic [SRCW-1:0] cmpl_id_i;
    logic            cmpl_ready_o;
    logic [2:0]      level_o;
    logic            err_o;
    logic [31:0]     claim_cnt_o;

    always #5 clk_i = ~clk_i;

    plic_claim_engine #(
        .SRCW      (SRCW),
        .FifoDepth (DEPTH),
        .CcAddr    (CC),
        .Holdoff   (HOLD)
    ) dut (
        .clk_i        (clk_i),
        .rst_i        (rst_i),
        .irq_i        (irq_i),
        .irq_id_i     (irq_id_i),
        .reg_req_o    (reg_req_o),
        .reg_rsp_i    (reg_rsp_i),
        .id_valid_o   (id_valid_o),
        .id_o         (id_o),
        .id_ready_i   (id_ready_i),
        .cmpl_valid_i (cmpl_valid_i),
        .cmpl_id_i    (cmpl_id_i),
        .cmpl_ready_o (cmpl_ready_o),
        .level_o      (level_o),
        .err_o        (err_o),
        .claim_cnt_o  (claim_cnt_o)
    );

    int total = 0;
    int bad   = 0;

    // Reference model state
    int              q[$];
    bit              err_m;
    int unsigned     cnt_m;
    int              cyc;
    int              idle_from;
    bit              trig_q;
    bit              outst;
    bit              out_wr;
    logic [SRCW-1:0] out_id;
    int              lat;
    int              n_claims;
    bit              prev_v;

    // Stimulus knobs (percentages)
    int p_irq, p_cmpl, p_pop, p_zero, p_err, p_idz, lat_min, lat_max, fix_id;
    bit force_pop;

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h (cycle %0d)", tag, act, exp, cyc);
        end
    endtask

    task automatic set_knobs(input int pi, input int pc, input int pp, input int pz,
                             input int pe, input int pidz, input int lmin, input int lmax);
        p_irq = pi; p_cmpl = pc; p_pop = pp; p_zero = pz;
        p_err = pe; p_idz = pidz; lat_min = lmin; lat_max = lmax;
    endtask

    task automatic do_reset();
        @(negedge clk_i);
        rst_i = 1'b1; irq_i = 1'b0; irq_id_i = '0; cmpl_valid_i = 1'b0;
        cmpl_id_i = '0; id_ready_i = 1'b0; reg_rsp_i = '0;
        @(negedge clk_i);
        cyc += 2;
        chk("rst_req_valid", reg_req_o.valid, 1'b0);
        chk("rst_level", 32'(level_o), 0);
        chk("rst_id_valid", id_valid_o, 1'b0);
        chk("rst_err", err_o, 1'b0);
        chk("rst_cnt", claim_cnt_o, 0);
        chk("rst_cmpl_ready", cmpl_ready_o, 1'b0);
        rst_i = 1'b0;
        q.delete(); err_m = 0; cnt_m = 0; outst = 0; trig_q = 0;
        idle_from = cyc; prev_v = 0;
    endtask

    task automatic step();
        bit              exp_v, rdy, rsp_err, cr_exp, pop, push;
        logic [31:0]     rd;
        logic [SRCW-1:0] rid;
        @(negedge clk_i);
        cyc++;
        chk("level", 32'(level_o), q.size());
        chk("id_valid", id_valid_o, q.size() != 0);
        if (q.size() != 0) chk("id_o", 32'(id_o), q[0]);
        chk("err", err_o, err_m);
        chk("claim_cnt", claim_cnt_o, cnt_m);

        // Engine is idle from idle_from on; it starts the next access one cycle after a trigger.
        exp_v = outst || (cyc - 1 >= idle_from && trig_q);
        chk("req_valid", reg_req_o.valid, exp_v);
        if (reg_req_o.valid && !prev_v && !reg_req_o.write) n_claims++;
        prev_v = reg_req_o.valid;
        if (exp_v && !outst) begin
            outst  = 1;
            out_wr = cmpl_valid_i;
            out_id = cmpl_id_i;
            lat    = $urandom_range(lat_min, lat_max);
        end
        if (exp_v && reg_req_o.valid) begin
            chk("req_addr", reg_req_o.addr, CC);
            chk("req_write", reg_req_o.write, out_wr);
            chk("req_wstrb", 32'(reg_req_o.wstrb), out_wr ? 32'hF : 32'h0);
            if (out_wr) chk("req_wdata", reg_req_o.wdata, 32'(out_id));
        end

        rdy = 0; rsp_err = 0; cr_exp = 0; push = 0; rd = $urandom; rid = '0;
        if (outst) begin
            if (lat == 0) begin
                rdy     = 1;
                rsp_err = $urandom_range(0, 99) < p_err;
                rd[SRCW-1:0] = ($urandom_range(0, 99) < p_zero) ? '0 : irq_id_i;
                rid     = rd[SRCW-1:0];
                if (rsp_err) err_m = 1;
                cr_exp  = out_wr;
                push    = !out_wr && !rsp_err && rid != '0;
                idle_from = out_wr ? cyc + 1 : cyc + HOLD + 1;
                outst   = 0;
            end else begin
                lat--;
            end
        end
        reg_rsp_i.ready = rdy;
        reg_rsp_i.error = rsp_err;
        reg_rsp_i.rdata = rd;

        id_ready_i = force_pop || ($urandom_range(0, 99) < p_pop);
        force_pop  = 0;
        pop = q.size() != 0 && id_ready_i;
        if (cmpl_valid_i && cr_exp) begin
            cmpl_valid_i = 1'b0;
        end else if (!cmpl_valid_i && $urandom_range(0, 99) < p_cmpl) begin
            cmpl_valid_i = 1'b1;
            cmpl_id_i    = SRCW'($urandom);
        end
        irq_i    = $urandom_range(0, 99) < p_irq;
        irq_id_i = (fix_id != 0) ? SRCW'(fix_id) :
                   ($urandom_range(0, 99) < p_idz) ? '0 : SRCW'($urandom_range(1, 31));
        #1;
        chk("cmpl_ready", cmpl_ready_o, cr_exp);

        trig_q = cmpl_valid_i || (irq_i && irq_id_i != '0 && q.size() < DEPTH);
        if (pop) void'(q.pop_front());
        if (push) begin
            q.push_back(int'(rid));
`ifdef PLIC_CLAIM_STATS_EN
            if (cnt_m != 32'hFFFF_FFFF) cnt_m++;
`endif
        end
    endtask

    initial begin
        bit seen;
        int n0;
        rst_i = 1'b1; irq_i = 1'b0; irq_id_i = '0; cmpl_valid_i = 1'b0;
        cmpl_id_i = '0; id_ready_i = 1'b0; reg_rsp_i = '0;
        cyc = 0; n_claims = 0; force_pop = 0; fix_id = 0;
        set_knobs(0, 0, 0, 0, 0, 0, 0, 0);
        do_reset();

        // Single claim of ID 5 with a 3-cycle PLIC response
        set_knobs(100, 0, 0, 0, 0, 0, 3, 3);
        fix_id = 5;
        repeat (12) step();
        fix_id = 0;

        // Fill the FIFO, then a single pop allows exactly one more claim
        do_reset();
        set_knobs(100, 0, 0, 0, 0, 0, 0, 2);
        repeat (60) step();
        chk("fill_level", 32'(level_o), DEPTH);
        n0 = n_claims;
        repeat (10) step();
        chk("full_no_claim", n_claims - n0, 0);
        force_pop = 1;
        repeat (20) step();
        chk("one_claim_after_pop", n_claims - n0, 1);

        // Completion and interrupt raised together
        do_reset();
        set_knobs(100, 100, 50, 0, 0, 0, 0, 2);
        repeat (30) step();

        // Spurious claims leave the FIFO empty
        do_reset();
        set_knobs(100, 0, 0, 100, 0, 0, 0, 2);
        repeat (20) step();
        chk("spur_level", 32'(level_o), 0);
        chk("spur_err", err_o, 1'b0);

        // Errored claims set the sticky flag and push nothing
        set_knobs(100, 0, 0, 0, 100, 0, 0, 2);
        repeat (20) step();
        chk("bus_err_flag", err_o, 1'b1);
        chk("bus_err_level", 32'(level_o), 0);
        set_knobs(100, 0, 0, 0, 0, 0, 0, 2);
        repeat (10) step();
        chk("bus_err_sticky", err_o, 1'b1);
        do_reset();

        // Reset while a claim waits for ready
        set_knobs(100, 0, 0, 0, 0, 0, 0, 1);
        repeat (8) step();
        set_knobs(100, 0, 0, 0, 0, 0, 50, 50);
        seen = 0;
        for (int i = 0; i < 20 && !seen; i++) begin
            step();
            seen = reg_req_o.valid && !reg_req_o.write;
        end
        chk("mid_claim_seen", seen, 1'b1);
        do_reset();

        // Three good claims
        set_knobs(100, 0, 100, 0, 0, 0, 0, 1);
        for (int i = 0; i < 60 && cnt_m < 3; i++) step();
`ifdef PLIC_CLAIM_STATS_EN
        chk("cnt_three", claim_cnt_o, 3);
`endif

        // Long random run
        do_reset();
        set_knobs(60, 15, 50, 15, 3, 10, 0, 4);
        repeat (3000) step();
        do_reset();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
